seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the calculator's multi-digit 7-segment display. It sequences one shared hex-to-segment decoder across DIGITS common-anode digits, one digit per refresh slot. It double-buffers the displayed word so that a new stack value is committed only at a frame boundary, which avoids tearing. An anti-ghosting blank interval opens each slot.

Parameters:
DIGITS, 8, number of digits scanned (legal 1..8); word width is 4*DIGITS
DIV, 50000, clock cycles per digit slot (legal >= 2)
BLANK_CYC, 16, cycles at slot start with all anodes off (legal 0..DIV-1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
en  in  1  display enable; low = dark, scan held at start
load  in  1  one-cycle strobe: capture data into pending buffer
data  in  4*DIGITS  hex word; nibble i shown on digit i, digit 0 rightmost
an  out  DIGITS  anode drives, active-low, at most one low at a time
seg  out  7  segments A..G = seg[0..6], active-low (0 = lit)
pending  out  1  high while loaded data awaits commit
frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Clock and reset: one clock clk; reset rst_n is synchronous and active-low.
- Reset values: an = all ones, seg = 7'h7F, pending = 0, frame_done = 0, shadow = 0, pend_buf = 0, cnt = 0, idx = 0, state = BLANK.
- Slot counter cnt runs 0..DIV-1 and wraps. On wrap, idx increments; idx wraps from DIGITS-1 to 0.
- State machine, evaluated per slot:
  - BLANK: active while cnt < BLANK_CYC. an all ones, seg 7'h7F.
  - ON: active for cnt >= BLANK_CYC. an[idx] = 0, seg = decode(shadow[4*idx+3:4*idx]).
  - BLANK -> ON at cnt == BLANK_CYC. ON -> BLANK at slot wrap. With BLANK_CYC = 0, BLANK is never entered and ON is held for the whole slot.
- an and seg are registered from the same state. They are always mutually aligned and appear one cycle after the cnt/idx values that select them.
- Frame boundary is the cycle with cnt == DIV-1 and idx == DIGITS-1. On that cycle:
  - frame_done = 1, registered, so the pulse is visible the following cycle.
  - If pending is high, shadow <= pend_buf and pending <= 0.
- load: pend_buf <= data and pending <= 1.
  - Back-to-back loads: last one wins.
  - Load on the same cycle as a frame boundary: the commit uses the old pend_buf, the new data stays pending for the next frame, and pending remains 1.
- en = 0: cnt, idx and state are forced to 0/0/BLANK, an is all ones, seg is 7'h7F, frame_done stays 0, and no commit occurs. Loads are still accepted. Scanning restarts at digit 0 slot start on the cycle after en rises.
- Reset mid-frame discards shadow and pend_buf immediately, and outputs go dark on the next edge.
- Decoder is purely combinational, full 0..F set, hex glyphs A b C d E F.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: for idx > 0, if every shadow nibble at positions idx..DIGITS-1 is zero, the digit's anode stays high for its whole slot. Timing is unchanged, frame length is constant, and digit 0 is always shown, so zero displays as a single "0".
- Undefined: all digits always lit, with leading zeros shown.

Decomposition:
- Shared package seg_pkg: seg_t (7-bit segment vector), SEG_OFF = 7'h7F, state enum {BLANK, ON}, digit-index width function clog2(DIGITS).
- One sub-module, seg_decode: a 4-bit to 7-bit active-low decoder, instantiated once and fed by the idx-selected nibble.

Test Plan (DIGITS=4, DIV=8, BLANK_CYC=2 unless stated):
1. Reset, then en=1 with no load -> every slot shows an=1111 for 2 cycles, then an = 1110, 1101, 1011, 0111 for 6 cycles each; seg=7'h40 ("0") during ON; frame_done pulses every 32 cycles.
2. load data=16'h12AF mid-frame -> pending=1; display is unchanged until the boundary; frame_done asserts and pending drops; the next frame shows seg 7'h0E (F) on digit 0, 7'h08 (A) on digit 1, 7'h24 (2) on digit 2, 7'h79 (1) on digit 3.
3. load on the exact frame-boundary cycle with 16'h0003, after a prior pending 16'h0001 -> next frame shows 0001; pending stays 1; the following frame shows 0003.
4. Drop en mid-slot on digit 2 -> next edge an=1111 and seg=7'h7F, no frame_done; re-raise en -> first ON is an=1110 at cnt=2.
5. Assert rst_n=0 for 1 cycle mid-ON -> outputs go dark next edge, shadow reads 0, pending=0.
6. With LEADING_ZERO_BLANK_EN defined, shadow=16'h0050 -> digits 2 and 3 keep an high for the whole slot; digits 0 and 1 are lit. With shadow=0, only digit 0 is lit, showing 7'h40.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

    // Width needed to index n items; never less than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Hex nibble to active-low 7-segment glyph, seg[0..6] = A..G.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode display scanner with frame-synchronous double buffer.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    output logic [DIGITS-1:0]     an,
    output seg_t                  seg,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int IW = clog2(DIGITS);
    localparam int CW = clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
    localparam logic [CW-1:0] BLK     = CW'(BLANK_CYC);

    scan_state_t          state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [IW-1:0]        idx, idx_nxt;
    logic [4*DIGITS-1:0]  shadow, pend_buf;
    logic [DIGITS-1:0]    an_nxt;
    seg_t                 seg_nxt, dec_seg;
    logic [3:0]           nib;
    logic                 boundary;

    assign boundary = (cnt == CNT_MAX) && (idx == IDX_MAX);
    assign nib      = shadow[4*idx +: 4];

    seg_decode u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
        idx_nxt   = (cnt != CNT_MAX) ? idx : ((idx == IDX_MAX) ? '0 : idx + 1'b1);
        an_nxt    = '1;
        seg_nxt   = SEG_OFF;
        if (!en) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                BLANK:   state_nxt = (cnt >= BLK) ? ON : BLANK;
                ON:      state_nxt = (cnt <  BLK) ? BLANK : ON;
                default: state_nxt = BLANK;
            endcase
            if (state_nxt == ON) begin
                an_nxt[idx] = 1'b0;
                seg_nxt     = dec_seg;
`ifdef LEADING_ZERO_BLANK_EN
                // Digit 0 is always shown so a zero value reads as one "0".
                if (idx != '0 && (shadow >> (4*idx)) == '0) begin
                    an_nxt  = '1;
                    seg_nxt = SEG_OFF;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            an         <= '1;
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
            pending    <= 1'b0;
            shadow     <= '0;
            pend_buf   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
            frame_done <= en && boundary;
            // Commit takes the old pend_buf even when a load lands on the boundary.
            if (en && boundary && pending)
                shadow <= pend_buf;
            if (load) begin
                pend_buf <= data;
                pending  <= 1'b1;
            end else if (en && boundary) begin
                pending  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a frame-position reference model.
module tb_seg_scan_ctrl;

    localparam int DIGITS    = 4;
    localparam int DIV       = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = DIGITS * DIV;
    localparam int W         = 4 * DIGITS;

    logic              clk = 1'b0;
    logic              rst_n, en, load;
    logic [W-1:0]      data;
    logic [DIGITS-1:0] an;
    logic [6:0]        seg;
    logic              pending, frame_done;

    seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data(data),
        .an(an), .seg(seg), .pending(pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: position within the frame, the shown word and the pending word.
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int              m_pos = 0;
    logic [W-1:0]    m_shown = '0, m_buf = '0;
    logic            m_pend = 1'b0, m_fd = 1'b0;
    logic [DIGITS-1:0] m_an = '1;
    logic [6:0]      m_seg = 7'h7F;

    task automatic model_step(input logic r, input logic e, input logic l, input logic [W-1:0] d);
        int dig, sc;
        logic [W-1:0] old_buf;
        if (!r) begin
            m_pos = 0; m_shown = '0; m_buf = '0; m_pend = 0; m_fd = 0;
            m_an = '1; m_seg = 7'h7F;
            return;
        end
        m_an = '1; m_seg = 7'h7F; m_fd = 0;
        old_buf = m_buf;
        if (!e) begin
            m_pos = 0;
        end else begin
            dig = m_pos / DIV;
            sc  = m_pos % DIV;
            if (sc >= BLANK_CYC) begin
                m_an  = ~(DIGITS'(1) << dig);
                m_seg = glyph[(m_shown >> (4*dig)) & 'hF];
`ifdef LEADING_ZERO_BLANK_EN
                if (dig > 0 && (m_shown >> (4*dig)) == 0) begin
                    m_an = '1; m_seg = 7'h7F;
                end
`endif
            end
            if (m_pos == FRAME - 1) begin
                m_fd = 1;
                if (m_pend) begin m_shown = old_buf; m_pend = 0; end
            end
            m_pos = (m_pos + 1) % FRAME;
        end
        if (l) begin m_buf = d; m_pend = 1; end
    endtask

    task automatic cycle(input string ph);
        @(posedge clk);
        model_step(rst_n, en, load, data);
        #1;
        chk({ph, ".an"}, 32'(an), 32'(m_an));
        chk({ph, ".seg"}, 32'(seg), 32'(m_seg));
        chk({ph, ".pending"}, 32'(pending), 32'(m_pend));
        chk({ph, ".frame_done"}, 32'(frame_done), 32'(m_fd));
    endtask

    initial begin
        int en_off;
        rst_n = 0; en = 0; load = 0; data = '0;
        repeat (2) cycle("reset");
        rst_n = 1; en = 1;
        // Idle display of zeros across a few frames.
        repeat (3 * FRAME) cycle("idle");
        // Known pattern, then a load landing exactly on the frame boundary.
        load = 1; data = 16'h12AF; cycle("load"); load = 0;
        repeat (2 * FRAME) cycle("pattern");
        load = 1; data = 16'h0001; cycle("load1"); load = 0;
        while (m_pos != FRAME - 1) cycle("seek");
        load = 1; data = 16'h0003; cycle("bnd_load"); load = 0;
        chk("bnd_pending_held", 32'(pending), 32'd1);
        repeat (2 * FRAME) cycle("after_bnd");
        // Randomized traffic with enable drops and occasional resets.
        en_off = 0;
        for (int i = 0; i < 4000; i++) begin
            if (en_off > 0) en_off--;
            else if ($urandom_range(0, 59) == 0) en_off = $urandom_range(1, 12);
            en    = (en_off == 0);
            load  = ($urandom_range(0, 24) == 0);
            data  = W'($urandom);
            if ($urandom_range(0, 30) == 0) data = '0;
            rst_n = ($urandom_range(0, 799) != 0);
            if ((i % 97) == 50 && m_pos == FRAME - 1) load = 1;
            cycle("rand");
        end
        rst_n = 0; load = 0; cycle("final_rst");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
